// File: rtl/regfile_wb_buffer.sv
// Write-back queue between the execute stage and the register-file array.
// Result writes are queued in a small FIFO and drained one per cycle into
// the array's single write port; a combinational lookup forwards queued but
// not-yet-written values to readers, newest entry first.
module regfile_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                      Clk,
    input  logic                      Clrn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             in_addr,
    input  logic [DW-1:0]             in_data,
    input  logic                      wb_stall,
    output logic                      wb_we,
    output logic [AW-1:0]             wb_addr,
    output logic [DW-1:0]             wb_data,
    input  logic [AW-1:0]             rd_addr,
    output logic                      fwd_hit,
    output logic [DW-1:0]             fwd_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;

    logic not_empty;
    logic full;
    logic push;
    logic pop;

    // Handshake and drain decisions; r0 writes are accepted but never queued.
    always_comb begin
        not_empty = (count != '0);
        full      = (count == CW'(DEPTH));
        in_ready  = Clrn && !full;
        push      = in_valid && in_ready && (in_addr != '0);
        pop       = not_empty && !wb_stall && Clrn;
        wb_we     = pop;
        wb_addr   = '0;
        wb_data   = '0;
        if (Clrn && not_empty) begin
            wb_addr = q_addr[rptr];
            wb_data = q_data[rptr];
        end
    end

    // Pointer and occupancy state; a reset drops everything still queued.
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge Clk) begin
        if (push) begin
            q_addr[wptr] <= in_addr;
            q_data[wptr] <= in_data;
        end
    end

    // Forwarding search from oldest to newest so the newest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PW'(i);
            if ((CW'(i) < count) && (q_addr[idx] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = q_data[idx];
            end
        end
        if (!Clrn || (rd_addr == '0)) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed bench for regfile_wb_buffer: a table of per-cycle vectors plus
// hand-written sequences for full-buffer refusal and mid-operation reset.
module tb_regfile_wb_buffer;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wb_stall;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    regfile_wb_buffer #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .wb_stall(wb_stall), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        st;
        logic [4:0]  rd;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_hit;
        logic [31:0] e_fd;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic st, input logic [4:0] rd,
                       input logic e_rdy, input logic e_we, input logic [4:0] e_wa,
                       input logic [31:0] e_wd, input logic e_hit,
                       input logic [31:0] e_fd, input logic [2:0] e_cnt);
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.st = st; t.rd = rd;
        t.e_rdy = e_rdy; t.e_we = e_we; t.e_wa = e_wa; t.e_wd = e_wd;
        t.e_hit = e_hit; t.e_fd = e_fd; t.e_cnt = e_cnt;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs in the low clock phase, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic st, input logic [4:0] rd);
        @(negedge Clk);
        in_valid = v; in_addr = a; in_data = d; wb_stall = st; rd_addr = rd;
        #1;
    endtask

    initial begin
        Clrn = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wb_stall = 1'b0; rd_addr = '0;

        // Reset state, with a request pending that must not be taken.
        drive(1'b1, 5'd3, 32'h1234, 1'b0, 5'd3);
        chk("reset in_ready", in_ready, 0);
        chk("reset wb_we", wb_we, 0);
        chk("reset fwd_hit", fwd_hit, 0);
        chk("reset wb_addr", wb_addr, 0);
        chk("reset wb_data", wb_data, 0);
        chk("reset fwd_data", fwd_data, 0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        Clrn = 1'b1;
        #1;
        chk("post-reset count", count, 0);

        //   v  a   d             st rd    rdy we wa  wd            hit fd            cnt
        // single entry, one-cycle latency
        add(1, 3, 32'hDEADBEEF, 0, 0,    1, 0, 0,  32'h0,        0, 32'h0,        0);
        add(0, 0, 32'h0,        0, 3,    1, 1, 3,  32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
        add(0, 0, 32'h0,        0, 3,    1, 0, 0,  32'h0,        0, 32'h0,        0);
        // stalled fill, fifth push refused, then in-order drain
        add(1, 1, 32'h101,      1, 0,    1, 0, 0,  32'h0,        0, 32'h0,        0);
        add(1, 2, 32'h102,      1, 0,    1, 0, 1,  32'h101,      0, 32'h0,        1);
        add(1, 3, 32'h103,      1, 0,    1, 0, 1,  32'h101,      0, 32'h0,        2);
        add(1, 4, 32'h104,      1, 0,    1, 0, 1,  32'h101,      0, 32'h0,        3);
        add(1, 5, 32'h105,      1, 5,    0, 0, 1,  32'h101,      0, 32'h0,        4);
        add(0, 0, 32'h0,        1, 2,    0, 0, 1,  32'h101,      1, 32'h102,      4);
        add(0, 0, 32'h0,        0, 0,    0, 1, 1,  32'h101,      0, 32'h0,        4);
        add(0, 0, 32'h0,        0, 0,    1, 1, 2,  32'h102,      0, 32'h0,        3);
        add(0, 0, 32'h0,        0, 0,    1, 1, 3,  32'h103,      0, 32'h0,        2);
        add(0, 0, 32'h0,        0, 0,    1, 1, 4,  32'h104,      0, 32'h0,        1);
        add(0, 0, 32'h0,        0, 0,    1, 0, 0,  32'h0,        0, 32'h0,        0);
        // duplicate address forwarding, newest wins; in-flight not forwarded
        add(1, 7, 32'h11,       1, 7,    1, 0, 0,  32'h0,        0, 32'h0,        0);
        add(1, 7, 32'h22,       1, 7,    1, 0, 7,  32'h11,       1, 32'h11,       1);
        add(0, 0, 32'h0,        1, 7,    1, 0, 7,  32'h11,       1, 32'h22,       2);
        add(0, 0, 32'h0,        1, 8,    1, 0, 7,  32'h11,       0, 32'h0,        2);
        add(0, 0, 32'h0,        0, 7,    1, 1, 7,  32'h11,       1, 32'h22,       2);
        add(0, 0, 32'h0,        0, 7,    1, 1, 7,  32'h22,       1, 32'h22,       1);
        add(0, 0, 32'h0,        0, 7,    1, 0, 0,  32'h0,        0, 32'h0,        0);
        // r0 write accepted and dropped; r0 never forwards
        add(1, 0, 32'hFFFF,     0, 0,    1, 0, 0,  32'h0,        0, 32'h0,        0);
        add(0, 0, 32'h0,        0, 0,    1, 0, 0,  32'h0,        0, 32'h0,        0);
        // simultaneous push and pop keeps count
        add(1, 9, 32'h99,       0, 0,    1, 0, 0,  32'h0,        0, 32'h0,        0);
        add(1, 10, 32'hAA,      0, 9,    1, 1, 9,  32'h99,       1, 32'h99,       1);
        add(0, 0, 32'h0,        0, 10,   1, 1, 10, 32'hAA,       1, 32'hAA,       1);
        add(0, 0, 32'h0,        0, 10,   1, 0, 0,  32'h0,        0, 32'h0,        0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].rd);
            chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d wb_we", i), wb_we, tbl[i].e_we);
            chk($sformatf("row%0d count", i), count, tbl[i].e_cnt);
            chk($sformatf("row%0d fwd_hit", i), fwd_hit, tbl[i].e_hit);
            if (tbl[i].e_cnt != 0) begin
                chk($sformatf("row%0d wb_addr", i), wb_addr, tbl[i].e_wa);
                chk($sformatf("row%0d wb_data", i), wb_data, tbl[i].e_wd);
            end
            if (tbl[i].e_hit)
                chk($sformatf("row%0d fwd_data", i), fwd_data, tbl[i].e_fd);
        end

        // Full buffer with in_valid held: refused while full, taken next cycle.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 5'(11 + i), 32'hA1 + 32'(i), 1'b1, 5'd0);
        drive(1'b1, 5'd15, 32'hA5, 1'b0, 5'd0);
        chk("full in_ready", in_ready, 0);
        chk("full wb_we", wb_we, 1);
        chk("full wb_addr", wb_addr, 11);
        chk("full count", count, 4);
        drive(1'b1, 5'd15, 32'hA5, 1'b0, 5'd0);
        chk("refill in_ready", in_ready, 1);
        chk("refill wb_addr", wb_addr, 12);
        chk("refill count", count, 3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            chk($sformatf("order%0d wb_we", i), wb_we, 1);
            chk($sformatf("order%0d wb_addr", i), wb_addr, 13 + i);
            chk($sformatf("order%0d wb_data", i), wb_data, 32'hA3 + 32'(i));
            chk($sformatf("order%0d count", i), count, 3 - i);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("order empty count", count, 0);

        // Mid-operation reset discards queued entries.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 5'(20 + i), 32'hC0 + 32'(i), 1'b1, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd20);
        Clrn = 1'b0;
        #1;
        chk("midrst in_ready", in_ready, 0);
        chk("midrst wb_we", wb_we, 0);
        chk("midrst fwd_hit", fwd_hit, 0);
        chk("midrst wb_addr", wb_addr, 0);
        chk("midrst wb_data", wb_data, 0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd20);
        Clrn = 1'b1;
        #1;
        chk("postrst count", count, 0);
        chk("postrst fwd_hit", fwd_hit, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("postrst%0d wb_we", i), wb_we, 0);
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd21);
        end
        chk("postrst final count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
